// File: rtl/sample_in_ball_shuffler_pipe.sv
// Sample-In-Ball shuffler: clears the coefficient RAM, then applies one (i, j, sign) update per cycle.
// Two-stage pipe (read issue, modify/write); the previous cycle's writes are forwarded over stale RAM data.
module sample_in_ball_shuffler_pipe #(
  parameter  int          SIB_SAMPLE_W   = 8,
  parameter  int          COEFF_W        = 23,
  parameter  int          COEFF_PER_WORD = 4,
  parameter  int unsigned Q              = 8380417,
  localparam int          OFS_W          = $clog2(COEFF_PER_WORD),
  localparam int          ADDR_W         = SIB_SAMPLE_W - OFS_W
) (
  input  logic                                        clk,
  input  logic                                        rst_b,
  input  logic                                        zeroize,
  input  logic                                        start_i,
  output logic                                        busy_o,
  output logic                                        done_o,
  input  logic                                        valid_i,
  output logic                                        ready_o,
  input  logic [SIB_SAMPLE_W-1:0]                     indexi_i,
  input  logic [SIB_SAMPLE_W-1:0]                     indexj_i,
  input  logic                                        sign_i,
  input  logic                                        last_i,
  output logic [1:0]                                  rd_cs_o,
  output logic [1:0][ADDR_W-1:0]                      rd_addr_o,
  input  logic [1:0][COEFF_PER_WORD-1:0][COEFF_W-1:0] rddata_i,
  output logic [1:0]                                  wr_en_o,
  output logic [1:0][ADDR_W-1:0]                      wr_addr_o,
  output logic [1:0][COEFF_PER_WORD-1:0][COEFF_W-1:0] wrdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [COEFF_W-1:0] NEG_ONE = COEFF_W'(Q - 1);

  typedef logic [COEFF_PER_WORD-1:0][COEFF_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DRAIN} state_t;

  state_t state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic done_nxt;
  logic accept;

  logic                    s1_valid;
  logic [SIB_SAMPLE_W-1:0] s1_i, s1_j;
  logic                    s1_sign, s1_last;

  logic [1:0]             fwd_en;
  logic [1:0][ADDR_W-1:0] fwd_addr;
  word_t [1:0]            fwd_data;

  logic [ADDR_W-1:0] s1_iw, s1_jw;
  logic [OFS_W-1:0]  s1_io, s1_jo;
  logic              same_word;
  word_t             word_i, word_j, wri, wrj;
  logic [COEFF_W-1:0] cj, nxt_j;

  assign busy_o = (state != IDLE);
  assign accept = valid_i & ready_o;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    ready_o   = 1'b0;
    unique case (state)
      IDLE: if (start_i) state_nxt = CLEAR;
      CLEAR: begin
        // Two words per cycle; the counter wraps back to 0 on the final pair.
        cnt_nxt = cnt + ADDR_W'(2);
        if (cnt == ADDR_W'(DEPTH - 2)) state_nxt = RUN;
      end
      RUN: begin
        ready_o = 1'b1;
        if (valid_i && last_i) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (s1_valid && s1_last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      cnt      <= '0;
      done_o   <= 1'b0;
      s1_valid <= 1'b0;
      s1_i     <= '0;
      s1_j     <= '0;
      s1_sign  <= 1'b0;
      s1_last  <= 1'b0;
      fwd_en   <= '0;
      fwd_addr <= '0;
      fwd_data <= '0;
    end else if (zeroize) begin
      state    <= IDLE;
      cnt      <= '0;
      done_o   <= 1'b0;
      s1_valid <= 1'b0;
      s1_i     <= '0;
      s1_j     <= '0;
      s1_sign  <= 1'b0;
      s1_last  <= 1'b0;
      fwd_en   <= '0;
      fwd_addr <= '0;
      fwd_data <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      done_o   <= done_nxt;
      s1_valid <= accept;
      if (accept) begin
        s1_i    <= indexi_i;
        s1_j    <= indexj_i;
        s1_sign <= sign_i;
        s1_last <= last_i;
      end
      fwd_en   <= wr_en_o;
      fwd_addr <= wr_addr_o;
      fwd_data <= wrdata_o;
    end
  end

  assign rd_cs_o      = {2{accept}};
  assign rd_addr_o[0] = indexj_i[SIB_SAMPLE_W-1:OFS_W];
  assign rd_addr_o[1] = indexi_i[SIB_SAMPLE_W-1:OFS_W];

  assign s1_iw     = s1_i[SIB_SAMPLE_W-1:OFS_W];
  assign s1_jw     = s1_j[SIB_SAMPLE_W-1:OFS_W];
  assign s1_io     = s1_i[OFS_W-1:0];
  assign s1_jo     = s1_j[OFS_W-1:0];
  assign same_word = (s1_iw == s1_jw);

  always_comb begin
    // RAM reads are read-before-write, so last cycle's write must override the returned word.
    word_j = rddata_i[0];
    if (fwd_en[0] && (fwd_addr[0] == s1_jw)) word_j = fwd_data[0];
    if (fwd_en[1] && (fwd_addr[1] == s1_jw)) word_j = fwd_data[1];
    word_i = rddata_i[1];
    if (fwd_en[0] && (fwd_addr[0] == s1_iw)) word_i = fwd_data[0];
    if (fwd_en[1] && (fwd_addr[1] == s1_iw)) word_i = fwd_data[1];

    cj    = word_j[s1_jo];
    nxt_j = s1_sign ? NEG_ONE : COEFF_W'(1);

    wrj        = word_j;
    wrj[s1_jo] = nxt_j;
    wri        = word_i;
    wri[s1_io] = cj;
    if (same_word) wri[s1_jo] = nxt_j;
  end

  always_comb begin
    wr_en_o   = '0;
    wr_addr_o = '0;
    wrdata_o  = '0;
    if (state == CLEAR) begin
      wr_en_o      = 2'b11;
      wr_addr_o[0] = cnt;
      wr_addr_o[1] = cnt + ADDR_W'(1);
    end else if (s1_valid) begin
      // A shared word is written once, through port 1, carrying both updates.
      wr_en_o      = same_word ? 2'b10 : 2'b11;
      wr_addr_o[0] = s1_jw;
      wr_addr_o[1] = s1_iw;
      wrdata_o[0]  = wrj;
      wrdata_o[1]  = wri;
    end
    if (zeroize) wr_en_o = '0;
  end

endmodule
